// File: rtl/inst_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
// Shared widths, fetch-controller state encoding and small address helpers
// used by the instruction-fetch controller, its bus interface and the bench.
// -----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

   localparam int ADDR_W      = 32;
   localparam int INST_W      = 32;
   localparam int FETCH_BYTES = 4;
   localparam int CNT_W       = 3;

   // Counter value at which all bytes of a word have been issued/received.
   localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_BYTES);
   // Receive count of the final byte of a word.
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FETCH_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_FILL  = 2'b10
   } state_e;

   // Force a byte address onto its containing word.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

   // Byte address of the cnt-th byte of the word at base; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  cnt);
      return base + {{(ADDR_W-CNT_W){1'b0}}, cnt};
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_if
// Bundles the three buses the fetch controller sits between:
//   IF side    : req_i, pc_i, flush_i -> inst_valid_o, inst_o, busy_o
//   cache side : cache_addr_o, cache_work_o, cache_data_o <- cache_data_i, cache_hit_i
//   memory side: mem_rd_o, mem_addr_o <- mem_gnt_i, mem_din_i
// Signal suffixes are from the controller's point of view.
// Modports:
//   slave  - the fetch controller (it serves requests from the IF stage)
//   master - the surrounding environment (IF stage, cache, byte memory)
// -----------------------------------------------------------------------------
interface inst_fetch_ctrl_if;
   import inst_fetch_ctrl_pkg::*;

   // IF stage
   logic              req_i;
   logic [ADDR_W-1:0] pc_i;
   logic              flush_i;
   logic              inst_valid_o;
   logic [INST_W-1:0] inst_o;
   logic              busy_o;

   // Instruction cache
   logic [ADDR_W-1:0] cache_addr_o;
   logic [INST_W-1:0] cache_data_i;
   logic              cache_hit_i;
   logic              cache_work_o;
   logic [INST_W-1:0] cache_data_o;

   // Byte-wide memory port
   logic              mem_rd_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic [7:0]        mem_din_i;

   modport slave (
      input  req_i, pc_i, flush_i,
      output inst_valid_o, inst_o, busy_o,
      output cache_addr_o, cache_work_o, cache_data_o,
      input  cache_data_i, cache_hit_i,
      output mem_rd_o, mem_addr_o,
      input  mem_gnt_i, mem_din_i
   );

   modport master (
      output req_i, pc_i, flush_i,
      input  inst_valid_o, inst_o, busy_o,
      input  cache_addr_o, cache_work_o, cache_data_o,
      output cache_data_i, cache_hit_i,
      input  mem_rd_o, mem_addr_o,
      output mem_gnt_i, mem_din_i
   );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction-fetch controller between the IF stage and a direct-mapped
// instruction cache. A request probes the cache in the same cycle; a hit is
// returned one cycle later. A miss reads the four bytes of the word over the
// byte-wide memory port, assembles them little-endian, writes the word into
// the cache (this block is the only cache writer) and hands it to IF.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   rdy  - global enable; low freezes every register
//   bus  - inst_fetch_ctrl_if.slave (IF, cache and memory buses)
//
// Configuration macro: INST_FETCH_ICACHE_EN
//   defined   - cache lookups and cache refill writes are active
//   undefined - every request misses; cache_work_o, cache_addr_o and
//               cache_data_o are held at zero; miss latency is unchanged
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   inst_fetch_ctrl_if.slave    bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic              rx_pend_q, rx_pend_d;     // a read was granted last cycle
   logic [INST_W-1:0] buf_q, buf_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              inst_valid_q, inst_valid_d;

   logic              hit_s;
   logic              issue_s;
   logic              grant_s;
   logic [ADDR_W-1:0] mem_addr_s;

`ifdef INST_FETCH_ICACHE_EN
   assign hit_s = bus.cache_hit_i;
`else
   // Without the cache every request is treated as a miss.
   logic cache_unused_s;
   assign hit_s          = 1'b0;
   assign cache_unused_s = ^{bus.cache_hit_i, bus.pc_i[1:0]};
`endif

   // Memory read issue: only in FETCH, while bytes remain, never on flush or freeze.
   always_comb begin
      issue_s    = 1'b0;
      mem_addr_s = {ADDR_W{1'b0}};
      if (state_q == ST_FETCH) begin
         issue_s    = rdy & ~bus.flush_i & (issue_cnt_q < FETCH_CNT);
         mem_addr_s = byte_addr(pc_q, issue_cnt_q);
      end else begin
         issue_s    = 1'b0;
         mem_addr_s = {ADDR_W{1'b0}};
      end
   end

   assign grant_s = issue_s & bus.mem_gnt_i;

   // Next-state and datapath update; with rdy low every register keeps its value.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      issue_cnt_d  = issue_cnt_q;
      rx_cnt_d     = rx_cnt_q;
      rx_pend_d    = rx_pend_q;
      buf_d        = buf_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;

      if (rdy) begin
         inst_valid_d = 1'b0;
         rx_pend_d    = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_i && !bus.flush_i) begin
                  if (hit_s) begin
                     inst_d       = bus.cache_data_i;
                     inst_valid_d = 1'b1;
                  end else begin
                     pc_d        = word_align(bus.pc_i);
                     issue_cnt_d = {CNT_W{1'b0}};
                     rx_cnt_d    = {CNT_W{1'b0}};
                     state_d     = ST_FETCH;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end

            ST_FETCH: begin
               if (bus.flush_i) begin
                  // Nothing can be granted this cycle, so no byte is left in flight;
                  // a byte returning now is simply dropped.
                  state_d = ST_IDLE;
               end else begin
                  if (grant_s) begin
                     issue_cnt_d = issue_cnt_q + 3'd1;
                     rx_pend_d   = 1'b1;
                  end else begin
                     rx_pend_d   = 1'b0;
                  end

                  if (rx_pend_q) begin
                     // Shift in from the top: after four bytes, byte 0 sits in [7:0].
                     buf_d    = {bus.mem_din_i, buf_q[INST_W-1:8]};
                     rx_cnt_d = rx_cnt_q + 3'd1;
                     if (rx_cnt_q == LAST_IDX) begin
                        state_d = ST_FILL;
                     end else begin
                        state_d = ST_FETCH;
                     end
                  end else begin
                     state_d = ST_FETCH;
                  end
               end
            end

            ST_FILL: begin
               if (bus.flush_i) begin
                  state_d = ST_IDLE;
               end else begin
                  inst_d       = buf_q;
                  inst_valid_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         inst_valid_d = inst_valid_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= {ADDR_W{1'b0}};
         issue_cnt_q  <= {CNT_W{1'b0}};
         rx_cnt_q     <= {CNT_W{1'b0}};
         rx_pend_q    <= 1'b0;
         buf_q        <= {INST_W{1'b0}};
         inst_q       <= {INST_W{1'b0}};
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         issue_cnt_q  <= issue_cnt_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_pend_q    <= rx_pend_d;
         buf_q        <= buf_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
      end
   end

`ifdef INST_FETCH_ICACHE_EN
   // Cache port: probe with the live PC in IDLE, refill at the latched PC in FILL.
   always_comb begin
      bus.cache_addr_o = pc_q;
      bus.cache_work_o = 1'b0;
      bus.cache_data_o = {INST_W{1'b0}};
      if (state_q == ST_IDLE) begin
         bus.cache_addr_o = bus.pc_i;
      end else begin
         bus.cache_addr_o = pc_q;
      end
      if (state_q == ST_FILL) begin
         bus.cache_work_o = rdy & ~bus.flush_i;
         bus.cache_data_o = buf_q;
      end else begin
         bus.cache_work_o = 1'b0;
         bus.cache_data_o = {INST_W{1'b0}};
      end
   end
`else
   assign bus.cache_addr_o = {ADDR_W{1'b0}};
   assign bus.cache_work_o = 1'b0;
   assign bus.cache_data_o = {INST_W{1'b0}};
`endif

   assign bus.mem_rd_o     = issue_s;
   assign bus.mem_addr_o   = mem_addr_s;
   assign bus.inst_o       = inst_q;
   assign bus.inst_valid_o = inst_valid_q;
   assign bus.busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Self-checking bench for inst_fetch_ctrl. Models the byte memory (with an
// optional alternating grant), the instruction cache (when
// INST_FETCH_ICACHE_EN is defined; otherwise a cache that always claims a hit
// with garbage data, which the controller must ignore) and keeps a queue of
// expected instruction words. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;
   import inst_fetch_ctrl_pkg::*;

`ifdef INST_FETCH_ICACHE_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   inst_fetch_ctrl_if bus();

   inst_fetch_ctrl dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic        gnt;
   } rd_t;
   rd_t rd_log[$];

   int          valid_cnt = 0;
   int          cw_cnt    = 0;
   logic [31:0] cw_addr   = 32'h0;
   logic [31:0] cw_data   = 32'h0;
   bit          gnt_alt   = 1'b0;

   logic [31:0] cache_mem [logic [31:0]];
   int          cache_gen = 0;
   logic [31:0] cache_key;

   // Byte memory contents: the word at 0x100 is 0x00100513, everything else
   // is a simple address hash.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (a[31:2] == 30'h40) begin
         case (a[1:0])
            2'd0:    return 8'h13;
            2'd1:    return 8'h05;
            2'd2:    return 8'h10;
            default: return 8'h00;
         endcase
      end
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   // Memory returns the granted byte one cycle later.
   always @(posedge clk) begin
      if (bus.mem_rd_o && bus.mem_gnt_i)
         bus.mem_din_i <= mem_byte(bus.mem_addr_o);
   end

   // Grant generator: always granting, or toggling every cycle.
   always @(posedge clk) begin
      #1;
      bus.mem_gnt_i = gnt_alt ? ~bus.mem_gnt_i : 1'b1;
   end

`ifdef INST_FETCH_ICACHE_EN
   // Fully tagged cache model: hit only for words previously written.
   always @(bus.cache_addr_o or cache_gen or rst) begin
      cache_key = {bus.cache_addr_o[31:2], 2'b00};
      if (cache_mem.exists(cache_key)) begin
         bus.cache_hit_i  = 1'b1;
         bus.cache_data_i = cache_mem[cache_key];
      end else begin
         bus.cache_hit_i  = 1'b0;
         bus.cache_data_i = 32'h0BAD_0BAD;
      end
   end
`else
   initial begin
      cache_key        = 32'h0;
      bus.cache_hit_i  = 1'b1;
      bus.cache_data_i = 32'hDEAD_BEEF;
   end
`endif

   // Monitor: counts valid pulses and cache writes, logs memory read cycles.
   always @(negedge clk) begin
      if (bus.inst_valid_o) valid_cnt++;
      if (bus.cache_work_o) begin
         cw_cnt++;
         cw_addr = bus.cache_addr_o;
         cw_data = bus.cache_data_o;
         cache_mem[{bus.cache_addr_o[31:2], 2'b00}] = bus.cache_data_o;
         cache_gen++;
      end
      if (bus.mem_rd_o) rd_log.push_back('{bus.mem_addr_o, bus.mem_gnt_i});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle request; t0 is the cycle count before the sampling edge.
   task automatic start_req(input logic [31:0] addr, input bit expect_word, output int t0);
      tick();
      bus.pc_i  = addr;
      bus.req_i = 1'b1;
      t0 = cyc;
      if (expect_word) exp_q.push_back(exp_word(addr));
      tick();
      bus.req_i = 1'b0;
   endtask

   task automatic wait_valid(input int t0, output bit seen, output logic [31:0] got, output int lat);
      seen = 1'b0;
      got  = 32'h0;
      lat  = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.inst_valid_o) begin
            seen = 1'b1;
            got  = bus.inst_o;
            lat  = cyc - t0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] got [8];
      string       nm  [8];
      rst = 1'b1; rdy = 1'b1;
      bus.req_i = 1'b0; bus.pc_i = 32'h0; bus.flush_i = 1'b0;
      bus.mem_gnt_i = 1'b1; bus.mem_din_i = 8'h00;
      repeat (3) @(negedge clk);
      got[0] = {31'h0, bus.inst_valid_o}; nm[0] = "rst_inst_valid";
      got[1] = bus.inst_o;                nm[1] = "rst_inst";
      got[2] = {31'h0, bus.busy_o};       nm[2] = "rst_busy";
      got[3] = {31'h0, bus.mem_rd_o};     nm[3] = "rst_mem_rd";
      got[4] = bus.mem_addr_o;            nm[4] = "rst_mem_addr";
      got[5] = {31'h0, bus.cache_work_o}; nm[5] = "rst_cache_work";
      got[6] = bus.cache_data_o;          nm[6] = "rst_cache_data";
      got[7] = bus.cache_addr_o;          nm[7] = "rst_cache_addr";
      for (int i = 0; i < 8; i++) begin
         chk_cnt++;
         if (got[i] !== 32'h0) $display("FAIL %s got=%h exp=00000000", nm[i], got[i]);
         else pass_cnt++;
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_cold_miss_then_hit();
      int t0, lat, cw0, v0;
      bit seen;
      logic [31:0] got, exp;
      cw0 = cw_cnt; v0 = valid_cnt;
      start_req(32'h0000_0100, 1'b1, t0);
      wait_valid(t0, seen, got, lat);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (!seen || got !== exp || got !== 32'h0010_0513)
         $display("FAIL cold_word got=%h exp=00100513 seen=%0d", got, seen);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== 7) $display("FAIL cold_latency got=%0d exp=7", lat);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (cw_cnt - cw0 !== (EN ? 1 : 0)) $display("FAIL cold_cache_writes got=%0d exp=%0d", cw_cnt - cw0, EN ? 1 : 0);
      else pass_cnt++;
`ifdef INST_FETCH_ICACHE_EN
      chk_cnt++;
      if (cw_addr !== 32'h0000_0100 || cw_data !== 32'h0010_0513)
         $display("FAIL cold_cache_wr got=%h/%h exp=00000100/00100513", cw_addr, cw_data);
      else pass_cnt++;
`endif
      start_req(32'h0000_0100, 1'b1, t0);
      wait_valid(t0, seen, got, lat);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (!seen || got !== exp) $display("FAIL second_word got=%h exp=%h seen=%0d", got, exp, seen);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== (EN ? 1 : 7)) $display("FAIL second_latency got=%0d exp=%0d", lat, EN ? 1 : 7);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (valid_cnt - v0 !== 2) $display("FAIL cold_valid_pulses got=%0d exp=2", valid_cnt - v0);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
`ifdef INST_FETCH_ICACHE_EN
      logic [31:0] exp;
      tick();
      bus.pc_i  = 32'h0000_0100;
      bus.req_i = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(exp_word(32'h0000_0100));
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) bus.req_i = 1'b0;
         @(negedge clk);
         exp = exp_q.pop_front();
         chk_cnt++;
         if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== exp)
            $display("FAIL b2b_hit_%0d got=%b/%h exp=1/%h", i, bus.inst_valid_o, bus.inst_o, exp);
         else pass_cnt++;
      end
      repeat (2) tick();
`endif
   endtask

   task automatic test_alt_grant();
      int t0, lat, stalls, idx;
      bit seen, ok;
      logic [31:0] got, exp;
      gnt_alt = 1'b1;
      tick();
      rd_log.delete();
      start_req(32'h0000_0200, 1'b1, t0);
      wait_valid(t0, seen, got, lat);
      gnt_alt = 1'b0;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (!seen || got !== exp) $display("FAIL alt_word got=%h exp=%h seen=%0d", got, exp, seen);
      else pass_cnt++;
      stalls = 0; idx = 0; ok = 1'b1;
      foreach (rd_log[i]) begin
         if (rd_log[i].addr !== 32'h0000_0200 + idx) ok = 1'b0;
         if (rd_log[i].gnt) idx++;
         else stalls++;
      end
      chk_cnt++;
      if (!ok || idx != 4) $display("FAIL alt_addr_seq ok=%0d grants=%0d exp ok=1 grants=4", ok, idx);
      else pass_cnt++;
      chk_cnt++;
      if (stalls < 3) $display("FAIL alt_stalls got=%0d exp>=3", stalls);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== 7 + stalls) $display("FAIL alt_latency got=%0d exp=%0d", lat, 7 + stalls);
      else pass_cnt++;
      repeat (2) tick();
   endtask

   task automatic test_flush();
      int t0, lat, cw0, v0;
      bit seen;
      logic [31:0] got, exp;
      cw0 = cw_cnt; v0 = valid_cnt;
      start_req(32'h0000_0280, 1'b0, t0);
      repeat (2) tick();
      @(negedge clk);
      chk_cnt++;
      if (bus.busy_o !== 1'b1) $display("FAIL flush_busy_fetch got=%b exp=1", bus.busy_o);
      else pass_cnt++;
      tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      repeat (12) @(negedge clk);
      chk_cnt++;
      if (valid_cnt !== v0 || cw_cnt !== cw0)
         $display("FAIL flush_quiet valid=%0d writes=%0d exp 0/0", valid_cnt - v0, cw_cnt - cw0);
      else pass_cnt++;
      chk_cnt++;
      if (bus.busy_o !== 1'b0) $display("FAIL flush_idle got=%b exp=0", bus.busy_o);
      else pass_cnt++;
      start_req(32'h0000_0300, 1'b1, t0);
      wait_valid(t0, seen, got, lat);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (!seen || got !== exp) $display("FAIL post_flush_word got=%h exp=%h seen=%0d", got, exp, seen);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== 7) $display("FAIL post_flush_latency got=%0d exp=7", lat);
      else pass_cnt++;
      repeat (2) tick();
   endtask

   task automatic test_rdy_stall();
      int t0, lat;
      bit seen;
      logic [31:0] got, exp;
      start_req(32'h0000_0340, 1'b1, t0);
      repeat (2) tick();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (bus.mem_rd_o !== 1'b0 || bus.cache_work_o !== 1'b0 || bus.busy_o !== 1'b1)
            $display("FAIL rdy_low_%0d rd/cw/busy=%b%b%b exp=001", i, bus.mem_rd_o, bus.cache_work_o, bus.busy_o);
         else pass_cnt++;
         tick();
      end
      rdy = 1'b1;
      wait_valid(t0, seen, got, lat);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (!seen || got !== exp) $display("FAIL rdy_word got=%h exp=%h seen=%0d", got, exp, seen);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== 10) $display("FAIL rdy_latency got=%0d exp=10", lat);
      else pass_cnt++;
      repeat (2) tick();
   endtask

   task automatic test_index_alias();
      int t0, lat, cw0;
      bit seen;
      logic [31:0] got, exp;
      logic [31:0] addrs [3];
      int          lats  [3];
      addrs[0] = 32'h0000_0400; lats[0] = 7;
      addrs[1] = 32'h0000_0000; lats[1] = 7;
      addrs[2] = 32'h0000_0400; lats[2] = EN ? 1 : 7;
      cw0 = cw_cnt;
      for (int i = 0; i < 3; i++) begin
         start_req(addrs[i], 1'b1, t0);
         wait_valid(t0, seen, got, lat);
         exp = exp_q.pop_front();
         chk_cnt++;
         if (!seen || got !== exp) $display("FAIL alias_word_%0d got=%h exp=%h seen=%0d", i, got, exp, seen);
         else pass_cnt++;
         chk_cnt++;
         if (lat !== lats[i]) $display("FAIL alias_latency_%0d got=%0d exp=%0d", i, lat, lats[i]);
         else pass_cnt++;
         repeat (2) tick();
      end
      chk_cnt++;
      if (cw_cnt - cw0 !== (EN ? 2 : 0)) $display("FAIL alias_cache_writes got=%0d exp=%0d", cw_cnt - cw0, EN ? 2 : 0);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_cold_miss_then_hit();
      test_back_to_back();
      test_alt_grant();
      test_flush();
      test_rdy_stall();
      test_index_alias();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
